// File: rtl/marquee_scroller.sv
// Scrolling-message driver for NUM_DIGITS active-low seven-segment digits (gfedcba).
// A writable symbol buffer is scrolled by a prescaler tick or a manual step, in wrap or bounce mode.
module marquee_scroller #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned PTR_W      = 3,
  parameter int unsigned SYM_W      = 4,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    dir,
  input  logic                    bounce,
  input  logic                    step,
  input  logic                    wr_en,
  input  logic [PTR_W-1:0]        wr_addr,
  input  logic [SYM_W-1:0]        wr_data,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [PTR_W-1:0]        pos,
  output logic                    tick
);

  localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PTR_W-1:0] POS_LAST = PTR_W'(MSG_LEN - 1);
  localparam logic [PTR_W-1:0] POS_PEN  = PTR_W'(MSG_LEN - 2);
  localparam logic [PTR_W-1:0] POS_ONE  = PTR_W'(1);

  logic [CNT_W-1:0]        r_cnt;
  logic                    r_tick;
  logic                    r_step_q;
  logic [PTR_W-1:0]        r_pos;
  logic                    r_bdir;
  logic [SYM_W-1:0]        r_buf [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] r_hex;

  logic                    w_tick_int;
  logic                    w_step_rise;
  logic                    w_adv;
  logic                    w_wr_ok;
  logic [PTR_W-1:0]        w_pos_nxt;
  logic                    w_bdir_nxt;
  logic [7*NUM_DIGITS-1:0] w_hex;

  function automatic logic [6:0] f_decode(input logic [SYM_W-1:0] sym);
    logic [6:0] seg;
    case (sym)
      SYM_W'(1): seg = 7'b0001110;
      SYM_W'(2): seg = 7'b0001100;
      SYM_W'(3): seg = 7'b0000010;
      SYM_W'(4): seg = 7'b0001000;
      SYM_W'(5): seg = 7'b0001001;
      SYM_W'(6): seg = 7'b0000110;
      SYM_W'(7): seg = 7'b1000111;
      SYM_W'(8): seg = 7'b1000000;
      SYM_W'(9): seg = 7'b0111111;
      default:   seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Buffer index shown on digit k; MSG_LEN is added first so the sum never goes negative.
  function automatic logic [PTR_W-1:0] f_digit_idx(input logic [PTR_W-1:0] p,
                                                   input int unsigned k);
    int unsigned sum;
    sum = 32'(p) + MSG_LEN - k;
    if (sum >= MSG_LEN) sum = sum - MSG_LEN;
    return sum[PTR_W-1:0];
  endfunction

  assign w_tick_int  = (r_cnt == CNT_LAST);
  assign w_step_rise = step & ~r_step_q;
  assign w_adv       = enable ? w_tick_int : w_step_rise;
  assign w_wr_ok     = wr_en && (32'(wr_addr) < MSG_LEN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_cnt    <= w_tick_int ? '0 : r_cnt + CNT_W'(1);
      r_tick   <= w_tick_int;
      r_step_q <= step;
    end
  end

  always_comb begin
    w_pos_nxt  = r_pos;
    w_bdir_nxt = r_bdir;
    if (!bounce) begin
      // Wrap mode keeps bdir tracking dir so a later bounce resumes in that direction.
      w_bdir_nxt = dir;
      if (w_adv) begin
        if (dir) w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + POS_ONE;
        else     w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - POS_ONE;
      end
    end else if (w_adv) begin
      if (r_bdir) begin
        if (r_pos == POS_LAST) begin
          w_bdir_nxt = 1'b0;
          w_pos_nxt  = POS_PEN;
        end else begin
          w_pos_nxt = r_pos + POS_ONE;
        end
      end else begin
        if (r_pos == '0) begin
          w_bdir_nxt = 1'b1;
          w_pos_nxt  = POS_ONE;
        end else begin
          w_pos_nxt = r_pos - POS_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pos  <= '0;
      r_bdir <= 1'b1;
    end else begin
      r_pos  <= w_pos_nxt;
      r_bdir <= w_bdir_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(MSG_LEN); i++) r_buf[i] <= '0;
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_hex = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_hex[7*k +: 7] = f_decode(r_buf[f_digit_idx(r_pos, k)]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_hex <= '1;
    else        r_hex <= w_hex;
  end

  assign hex_out = r_hex;
  assign pos     = r_pos;
  assign tick    = r_tick;

endmodule
